// File: rtl/ifu_inst_buffer_pkg.sv
// Shared front-end definitions for the instruction buffer: sizing constants,
// the buffered entry type and the lane popcount helper.
package ifu_inst_buffer_pkg;

    localparam int BLOCK_INST_SIZE = 8;
    localparam int FETCH_WIDTH     = 4;
    localparam int FSQ_WIDTH       = 6;

    localparam int IBUF_SIZE  = 16;
    localparam int IBUF_WIDTH = $clog2(IBUF_SIZE);
    localparam int CNT_WIDTH  = IBUF_WIDTH + 1;
    localparam int POP_WIDTH  = $clog2(BLOCK_INST_SIZE) + 1;

    typedef struct packed {
        logic [31:0]          inst;
        logic [FSQ_WIDTH-1:0] fsqIdx;
    } IBufEntry;

    // Lane masks are contiguous from lane 0, so the popcount equals the lane count.
    function automatic logic [POP_WIDTH-1:0] popcount(input logic [BLOCK_INST_SIZE-1:0] mask);
        logic [POP_WIDTH-1:0] sum;
        sum = '0;
        for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
            sum = sum + POP_WIDTH'(mask[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/ifu_inst_buffer.sv
// Instruction buffer between predecode and decode: circular FIFO that accepts a
// block of lanes per cycle and presents up to FETCH_WIDTH oldest instructions.
// Optional IBUF_PERF_EN adds saturating full/empty cycle counters.
module ifu_inst_buffer
    import ifu_inst_buffer_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    // predecode -> ibuffer
    input  logic [BLOCK_INST_SIZE-1:0]            enq_en,
    input  logic [BLOCK_INST_SIZE-1:0][31:0]      enq_inst,
    input  logic [FSQ_WIDTH-1:0]                  enq_fsqIdx,
    output logic                                  full,
    // ibuffer -> decode
    input  logic                                  deq_ready,
    output logic [FETCH_WIDTH-1:0]                deq_valid,
    output logic [FETCH_WIDTH-1:0][31:0]          deq_inst,
    output logic [FETCH_WIDTH-1:0][FSQ_WIDTH-1:0] deq_fsqIdx
`ifdef IBUF_PERF_EN
    ,
    output logic [31:0]                           perf_full_cycles,
    output logic [31:0]                           perf_empty_cycles
`endif
);

    IBufEntry              mem [IBUF_SIZE];
    logic [IBUF_WIDTH-1:0] head;
    logic [IBUF_WIDTH-1:0] tail;
    logic [CNT_WIDTH-1:0]  count;

    logic                  enq_fire;
    logic                  deq_fire;
    logic [POP_WIDTH-1:0]  enq_num;
    logic [POP_WIDTH-1:0]  deq_num;
    logic [POP_WIDTH-1:0]  enq_add;
    logic [POP_WIDTH-1:0]  deq_sub;

    // Reserve a whole block of space so an accepted block always fits.
    assign full = count > CNT_WIDTH'(IBUF_SIZE - BLOCK_INST_SIZE);

    assign enq_num  = popcount(enq_en);
    assign deq_num  = popcount(BLOCK_INST_SIZE'(deq_valid));
    assign enq_fire = !full && !flush && (enq_en != '0);
    assign deq_fire = deq_ready && !flush;
    assign enq_add  = enq_fire ? enq_num : '0;
    assign deq_sub  = deq_fire ? deq_num : '0;

    // Presentation reads registered state only, so new entries appear a cycle later.
    always_comb begin
        deq_valid  = '0;
        deq_inst   = '0;
        deq_fsqIdx = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            deq_valid[i]  = count > CNT_WIDTH'(i);
            deq_inst[i]   = mem[head + IBUF_WIDTH'(i)].inst;
            deq_fsqIdx[i] = mem[head + IBUF_WIDTH'(i)].fsqIdx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + IBUF_WIDTH'(enq_add);
            head  <= head + IBUF_WIDTH'(deq_sub);
            count <= count + CNT_WIDTH'(enq_add) - CNT_WIDTH'(deq_sub);
        end
    end

    // NOTE: storage has no reset; validity is tracked entirely by head/tail/count,
    // which keeps the array a plain RAM without a reset network.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
            if (enq_fire && enq_en[i]) begin
                mem[tail + IBUF_WIDTH'(i)] <= '{inst: enq_inst[i], fsqIdx: enq_fsqIdx};
            end
        end
    end

`ifdef IBUF_PERF_EN
    // Counters survive flush so they measure whole-run occupancy behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_full_cycles  <= '0;
            perf_empty_cycles <= '0;
        end else begin
            if (full && (perf_full_cycles != '1)) begin
                perf_full_cycles <= perf_full_cycles + 32'd1;
            end
            if ((count == '0) && (perf_empty_cycles != '1)) begin
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_ifu_inst_buffer.sv
// Scoreboard bench for ifu_inst_buffer: a queue model of the buffer contents
// predicts every presented group, the full flag and (optionally) perf counters.
module tb_ifu_inst_buffer;
    import ifu_inst_buffer_pkg::*;

    logic                                  clk;
    logic                                  rst;
    logic                                  flush;
    logic [BLOCK_INST_SIZE-1:0]            enq_en;
    logic [BLOCK_INST_SIZE-1:0][31:0]      enq_inst;
    logic [FSQ_WIDTH-1:0]                  enq_fsqIdx;
    logic                                  full;
    logic                                  deq_ready;
    logic [FETCH_WIDTH-1:0]                deq_valid;
    logic [FETCH_WIDTH-1:0][31:0]          deq_inst;
    logic [FETCH_WIDTH-1:0][FSQ_WIDTH-1:0] deq_fsqIdx;
`ifdef IBUF_PERF_EN
    logic [31:0]                           perf_full_cycles;
    logic [31:0]                           perf_empty_cycles;
`endif

    ifu_inst_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .enq_en     (enq_en),
        .enq_inst   (enq_inst),
        .enq_fsqIdx (enq_fsqIdx),
        .full       (full),
        .deq_ready  (deq_ready),
        .deq_valid  (deq_valid),
        .deq_inst   (deq_inst),
        .deq_fsqIdx (deq_fsqIdx)
`ifdef IBUF_PERF_EN
        ,
        .perf_full_cycles  (perf_full_cycles),
        .perf_empty_cycles (perf_empty_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    IBufEntry    sb [$];
    logic [31:0] exp_full_cycles;
    logic [31:0] exp_empty_cycles;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Asserts reset away from the clock edge, checks the async clear, releases mid-cycle.
    task automatic do_reset();
        rst       = 1'b0;
        flush     = 1'b0;
        enq_en    = '0;
        enq_inst  = '0;
        enq_fsqIdx = '0;
        deq_ready = 1'b0;
        #1;
        check("rst_full", 64'(full), 64'd0);
        check("rst_valid", 64'(deq_valid), 64'd0);
        sb.delete();
        exp_full_cycles  = '0;
        exp_empty_cycles = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One clock: drive inputs, compare presented outputs with the scoreboard,
    // then update the scoreboard with what the edge should do.
    task automatic cycle(input logic [7:0] en, input logic [31:0] base,
                         input logic [5:0] fsq, input logic rdy, input logic fl);
        int       nv;
        logic     exp_full;
        logic [3:0] exp_valid;
        IBufEntry e;
        enq_en     = en;
        enq_fsqIdx = fsq;
        deq_ready  = rdy;
        flush      = fl;
        for (int i = 0; i < BLOCK_INST_SIZE; i++) enq_inst[i] = base + 32'(i);

        nv        = (sb.size() > FETCH_WIDTH) ? FETCH_WIDTH : sb.size();
        exp_full  = sb.size() > (IBUF_SIZE - BLOCK_INST_SIZE);
        exp_valid = '0;
        for (int i = 0; i < nv; i++) exp_valid[i] = 1'b1;

        check("full", 64'(full), 64'(exp_full));
        check("deq_valid", 64'(deq_valid), 64'(exp_valid));
        for (int i = 0; i < nv; i++) begin
            check($sformatf("deq_inst%0d", i), 64'(deq_inst[i]), 64'(sb[i].inst));
            check($sformatf("deq_fsq%0d", i), 64'(deq_fsqIdx[i]), 64'(sb[i].fsqIdx));
        end

        if (exp_full) exp_full_cycles++;
        if (sb.size() == 0) exp_empty_cycles++;

        if (fl) begin
            sb.delete();
        end else begin
            if (rdy) for (int i = 0; i < nv; i++) void'(sb.pop_front());
            if (!exp_full) begin
                for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
                    if (en[i]) begin
                        e.inst   = base + 32'(i);
                        e.fsqIdx = fsq;
                        sb.push_back(e);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 6; k++) cycle(8'h00, 32'h0, 6'd0, 1'b1, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        do_reset();

        // single half-block: 0x1..0x4 with fsqIdx 3, visible next cycle
        cycle(8'h0F, 32'h1, 6'd3, 1'b0, 1'b0);
        cycle(8'h00, 32'h0, 6'd0, 1'b0, 1'b0);
        check("first_group", 64'(deq_inst[3]), 64'h4);
        drain();

        // fill to 16 entries; third block must be dropped while full
        cycle(8'hFF, 32'h100, 6'd5, 1'b0, 1'b0);
        cycle(8'hFF, 32'h200, 6'd6, 1'b0, 1'b0);
        cycle(8'hFF, 32'h300, 6'd7, 1'b0, 1'b0);
        cycle(8'h00, 32'h0, 6'd0, 1'b0, 1'b0);
        drain();

        // count 6, then enqueue 3 while dequeuing 4 -> 5 entries
        cycle(8'h3F, 32'h400, 6'd8, 1'b0, 1'b0);
        cycle(8'h07, 32'h500, 6'd9, 1'b1, 1'b0);
        drain();

        // head lands on 14; the next 4-entry block wraps 14,15,0,1
        cycle(8'h01, 32'h600, 6'd10, 1'b0, 1'b0);
        cycle(8'h00, 32'h0, 6'd0, 1'b1, 1'b0);
        cycle(8'h0F, 32'h700, 6'd11, 1'b0, 1'b0);
        cycle(8'h00, 32'h0, 6'd0, 1'b0, 1'b0);
        drain();

        // count 10 then flush with competing enq/deq
        cycle(8'hFF, 32'h800, 6'd12, 1'b0, 1'b0);
        cycle(8'h03, 32'h900, 6'd13, 1'b0, 1'b0);
        cycle(8'hFF, 32'hA00, 6'd14, 1'b1, 1'b1);
        cycle(8'h00, 32'h0, 6'd0, 1'b0, 1'b0);
        check("flush_valid", 64'(deq_valid), 64'd0);

        // reset mid-operation discards contents
        cycle(8'hFF, 32'hB00, 6'd15, 1'b0, 1'b0);
        do_reset();
        cycle(8'h0F, 32'hC00, 6'd16, 1'b0, 1'b0);
        cycle(8'h00, 32'h0, 6'd0, 1'b1, 1'b0);
        cycle(8'h00, 32'h0, 6'd0, 1'b0, 1'b0);

        // occupancy profile: held full 5 edges, then empty for 3 idle edges
        do_reset();
        cycle(8'hFF, 32'hD00, 6'd17, 1'b0, 1'b0);
        cycle(8'hFF, 32'hE00, 6'd18, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(8'h00, 32'h0, 6'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(8'h00, 32'h0, 6'd0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle(8'h00, 32'h0, 6'd0, 1'b0, 1'b0);
`ifdef IBUF_PERF_EN
        check("perf_full", 64'(perf_full_cycles), 64'(exp_full_cycles));
        check("perf_empty", 64'(perf_empty_cycles), 64'(exp_empty_cycles));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
